// File: rtl/priority_arbiter.sv
// Priority arbiter: grants one of WIDTH requesters access to a shared resource.
// A grant locks until the owner drops its request, enable falls, or the optional
// hold timeout fires while another requester is waiting. Every release is
// followed by exactly one idle cycle before the next grant.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   enable     low forces release and blocks new grants
//   latch      permits a new arbitration decision while idle
//   requests   request vector, bit i = requester i
//   grants     registered one-hot grant (or zero)
//   grant_idx  registered binary index of the owner, 0 when idle
//   granted    combinational OR of (grants & requests)
//   busy       registered, high while a grant is held
module priority_arbiter #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned RR_MODE = 0,
   parameter int unsigned TIMEOUT = 0,
   localparam int unsigned IDXW   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             latch,
   input  logic [WIDTH-1:0] requests,
   output logic [WIDTH-1:0] grants,
   output logic [IDXW-1:0]  grant_idx,
   output logic             granted,
   output logic             busy
);

   localparam int unsigned HCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   // Saturation value of the hold counter; 0 when the timeout is disabled.
   localparam logic [HCW-1:0] HMAX = HCW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic {StIdle, StGranted} state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   grants_q, grants_d;
   logic [IDXW-1:0]    idx_q, idx_d;
   logic               busy_q, busy_d;
   logic [IDXW-1:0]    ptr_q, ptr_d;
   logic [HCW-1:0]     hcnt_q, hcnt_d;

   logic               win_found;
   logic [IDXW-1:0]    win_idx;
   logic               owner_req;
   logic               others_req;
   logic               timeout_hit;

   // Winner search: scan upward from ptr (always 0 in fixed-priority mode).
   always_comb begin
      int unsigned pos;
      win_found = 1'b0;
      win_idx   = '0;
      pos       = 0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         pos = (RR_MODE != 0) ? ((32'(ptr_q) + i) % WIDTH) : i;
         if (!win_found && requests[pos]) begin
            win_found = 1'b1;
            win_idx   = IDXW'(pos);
         end
      end
   end

   assign owner_req   = |(requests & grants_q);
   assign others_req  = |(requests & ~grants_q);
   assign timeout_hit = (TIMEOUT > 0) && (hcnt_q == HMAX) && others_req;

   always_comb begin
      state_d  = state_q;
      grants_d = grants_q;
      idx_d    = idx_q;
      busy_d   = busy_q;
      ptr_d    = ptr_q;
      hcnt_d   = hcnt_q;
      unique case (state_q)
         StIdle: begin
            if (enable && latch && win_found) begin
               state_d  = StGranted;
               grants_d = WIDTH'(1) << win_idx;
               idx_d    = win_idx;
               busy_d   = 1'b1;
               hcnt_d   = '0;
               if (RR_MODE != 0) begin
                  ptr_d = (32'(win_idx) == WIDTH - 1) ? '0 : win_idx + IDXW'(1);
               end
            end
         end
         StGranted: begin
            if (!enable || !owner_req || timeout_hit) begin
               state_d  = StIdle;
               grants_d = '0;
               idx_d    = '0;
               busy_d   = 1'b0;
               hcnt_d   = '0;
            end else if (hcnt_q != HMAX) begin
               // Saturate so a lone owner is never evicted.
               hcnt_d = hcnt_q + HCW'(1);
            end
         end
         default: begin
            state_d  = StIdle;
            grants_d = '0;
            idx_d    = '0;
            busy_d   = 1'b0;
            hcnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= StIdle;
         grants_q <= '0;
         idx_q    <= '0;
         busy_q   <= 1'b0;
         ptr_q    <= '0;
         hcnt_q   <= '0;
      end else begin
         state_q  <= state_d;
         grants_q <= grants_d;
         idx_q    <= idx_d;
         busy_q   <= busy_d;
         ptr_q    <= ptr_d;
         hcnt_q   <= hcnt_d;
      end
   end

   assign grants    = grants_q;
   assign grant_idx = idx_q;
   assign busy      = busy_q;
   assign granted   = owner_req;

endmodule

// File: tb/tb_priority_arbiter.sv
// Directed bench for priority_arbiter: fixed-priority, round-robin with a
// 4-cycle hold timeout, and fixed-priority with a 1-cycle timeout, all fed from
// the same stimulus.
module tb_priority_arbiter;

   logic       clk;
   logic       rst;
   logic       enable;
   logic       latch;
   logic [7:0] requests;

   logic [7:0] fp_grants, rr_grants, t1_grants;
   logic [2:0] fp_idx, rr_idx, t1_idx;
   logic       fp_granted, rr_granted, t1_granted;
   logic       fp_busy, rr_busy, t1_busy;

   int checks = 0;
   int errors = 0;

   priority_arbiter #(.WIDTH(8), .RR_MODE(0), .TIMEOUT(0)) u_fp (
      .clk(clk), .rst(rst), .enable(enable), .latch(latch), .requests(requests),
      .grants(fp_grants), .grant_idx(fp_idx), .granted(fp_granted), .busy(fp_busy)
   );

   priority_arbiter #(.WIDTH(8), .RR_MODE(1), .TIMEOUT(4)) u_rr (
      .clk(clk), .rst(rst), .enable(enable), .latch(latch), .requests(requests),
      .grants(rr_grants), .grant_idx(rr_idx), .granted(rr_granted), .busy(rr_busy)
   );

   priority_arbiter #(.WIDTH(8), .RR_MODE(0), .TIMEOUT(1)) u_t1 (
      .clk(clk), .rst(rst), .enable(enable), .latch(latch), .requests(requests),
      .grants(t1_grants), .grant_idx(t1_idx), .granted(t1_granted), .busy(t1_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       en;
      logic       lt;
      logic [7:0] req;
      logic [7:0] exp_g;
      logic [2:0] exp_idx;
      logic       exp_busy;
      logic       exp_gr;
   } vec_t;

   vec_t vecs[15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst      = 1'b0;
      enable   = 1'b0;
      latch    = 1'b0;
      requests = 8'h00;
      #2;
      rst = 1'b1;
   endtask

   initial begin
      logic [7:0] onehot;
      rst      = 1'b0;
      enable   = 1'b0;
      latch    = 1'b0;
      requests = 8'h00;

      vecs[0]  = '{1'b1, 1'b1, 8'h68, 8'h08, 3'd3, 1'b1, 1'b1};
      vecs[1]  = '{1'b1, 1'b0, 8'h68, 8'h08, 3'd3, 1'b1, 1'b1};
      vecs[2]  = '{1'b1, 1'b1, 8'h6F, 8'h08, 3'd3, 1'b1, 1'b1};
      vecs[3]  = '{1'b1, 1'b1, 8'h60, 8'h00, 3'd0, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, 1'b1, 8'h60, 8'h20, 3'd5, 1'b1, 1'b1};
      vecs[5]  = '{1'b0, 1'b1, 8'h60, 8'h00, 3'd0, 1'b0, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 1'b1, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0};
      vecs[8]  = '{1'b1, 1'b1, 8'h80, 8'h80, 3'd7, 1'b1, 1'b1};
      vecs[9]  = '{1'b1, 1'b1, 8'h81, 8'h80, 3'd7, 1'b1, 1'b1};
      vecs[10] = '{1'b1, 1'b1, 8'h01, 8'h00, 3'd0, 1'b0, 1'b0};
      vecs[11] = '{1'b1, 1'b1, 8'h01, 8'h01, 3'd0, 1'b1, 1'b1};
      vecs[12] = '{1'b1, 1'b1, 8'h20, 8'h00, 3'd0, 1'b0, 1'b0};
      vecs[13] = '{1'b1, 1'b1, 8'h20, 8'h20, 3'd5, 1'b1, 1'b1};
      vecs[14] = '{1'b1, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};

      // Reset state
      #2;
      check("reset_fp_grants", 32'(fp_grants), 32'h0);
      check("reset_fp_idx", 32'(fp_idx), 32'h0);
      check("reset_fp_busy", 32'(fp_busy), 32'h0);
      check("reset_rr_grants", 32'(rr_grants), 32'h0);
      rst = 1'b1;

      // Fixed-priority table
      for (int i = 0; i < 15; i++) begin
         enable   = vecs[i].en;
         latch    = vecs[i].lt;
         requests = vecs[i].req;
         step();
         check($sformatf("vec%0d_grants", i), 32'(fp_grants), 32'(vecs[i].exp_g));
         check($sformatf("vec%0d_idx", i), 32'(fp_idx), 32'(vecs[i].exp_idx));
         check($sformatf("vec%0d_busy", i), 32'(fp_busy), 32'(vecs[i].exp_busy));
         check($sformatf("vec%0d_granted", i), 32'(fp_granted), 32'(vecs[i].exp_gr));
      end

      // Round-robin rotation 0..7,0 with one dead cycle between grants
      apply_reset();
      enable = 1'b1;
      latch  = 1'b1;
      for (int k = 0; k < 9; k++) begin
         requests = 8'hFF;
         step();
         onehot = 8'h01 << (k % 8);
         check($sformatf("rr%0d_grants", k), 32'(rr_grants), 32'(onehot));
         check($sformatf("rr%0d_idx", k), 32'(rr_idx), 32'(k % 8));
         requests = 8'hFF & ~onehot;
         #1;
         if (k == 0) begin
            // Owner drop shows on granted before the registered grant clears
            check("rr_granted_comb_drop", 32'(rr_granted), 32'h0);
            check("rr_busy_before_release", 32'(rr_busy), 32'h1);
         end
         step();
         check($sformatf("rr%0d_dead_grants", k), 32'(rr_grants), 32'h0);
         check($sformatf("rr%0d_dead_busy", k), 32'(rr_busy), 32'h0);
      end

      // Hold timeout: TIMEOUT=4 round-robin and TIMEOUT=1 fixed-priority
      apply_reset();
      enable   = 1'b1;
      latch    = 1'b1;
      requests = 8'h03;
      for (int c = 1; c <= 4; c++) begin
         step();
         check($sformatf("to4_hold%0d", c), 32'(rr_grants), 32'h01);
         if (c == 1) check("to1_grant", 32'(t1_grants), 32'h01);
         if (c == 2) check("to1_evict", 32'(t1_grants), 32'h00);
         if (c == 3) check("to1_regrant", 32'(t1_grants), 32'h01);
      end
      step();
      check("to4_release", 32'(rr_grants), 32'h00);
      step();
      check("to4_next_owner", 32'(rr_grants), 32'h02);
      check("to4_next_idx", 32'(rr_idx), 32'h1);

      // Lone owner is never evicted
      requests = 8'h01;
      step();
      check("lone_release_prev", 32'(rr_grants), 32'h00);
      step();
      check("lone_grant", 32'(rr_grants), 32'h01);
      for (int c = 0; c < 12; c++) begin
         step();
         check($sformatf("lone_hold%0d", c), 32'(rr_grants), 32'h01);
      end

      // Asynchronous reset mid-grant, pointer returns to 0
      #2;
      rst = 1'b0;
      #1;
      check("async_rst_grants", 32'(rr_grants), 32'h0);
      check("async_rst_idx", 32'(rr_idx), 32'h0);
      check("async_rst_busy", 32'(rr_busy), 32'h0);
      #2;
      rst      = 1'b1;
      requests = 8'hFF;
      step();
      check("post_rst_grants", 32'(rr_grants), 32'h01);
      check("post_rst_idx", 32'(rr_idx), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/priority_arbiter.md
Name: priority_arbiter

Overview:
- Parametrised successor to the fixed-priority grant selector.
- Arbitrates WIDTH requesters onto one shared resource, such as a bus or FIFO port.
- Modes: fixed priority or round-robin.
- A grant is held (locked) until the owner drops its request, the arbiter is disabled, or an optional hold timeout fires while other requesters wait.
- Sits between requesting masters and a shared resource in the bus interface logic.

Parameters:
- WIDTH, 8, number of requesters; must be at least 1.
- RR_MODE, 0, 0 = fixed priority (lowest index wins); 1 = round-robin.
- TIMEOUT, 0, maximum hold cycles while another request is pending; 0 disables the timeout.
- IDXW, derived, max(1, clog2(WIDTH)), width of grant_idx; not user-set.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  reset: one clock; reset is asynchronous and active-low.
- enable  input  1  arbiter enable; low forces release and blocks new grants.
- latch  input  1  permits a new arbitration decision this cycle.
- requests  input  WIDTH  request vector; bit i is requester i.
- grants  output  WIDTH  registered one-hot grant, or all-zero.
- grant_idx  output  IDXW  registered binary index of the granted requester; 0 when idle.
- granted  output  1  combinational: OR of (grants & requests).
- busy  output  1  registered; 1 while in state GRANTED.

Behaviour:
- Reset (rst low, asynchronous):
  - grants=0, grant_idx=0, busy=0.
  - State IDLE, round-robin pointer ptr=0, hold counter hcnt=0.
  - Takes effect without a clock edge; deassertion is sampled synchronously.
- States: IDLE and GRANTED.
- IDLE:
  - grants=0.
  - If enable && latch && |requests at a rising edge: compute the winner, load grants=onehot(winner), grant_idx=winner, busy=1, hcnt=0; next state GRANTED.
  - Latency: request sampled at edge N, grant visible after edge N.
  - Otherwise stay in IDLE.
- Winner selection:
  - RR_MODE=0: lowest set index.
  - RR_MODE=1: first set bit scanning upward from ptr, wrapping at WIDTH-1 to 0.
  - Exactly one bit is ever set in grants.
- Pointer update, RR_MODE=1 only:
  - On each new grant, ptr <= (winner+1) mod WIDTH.
  - ptr is unchanged in RR_MODE=0.
- GRANTED, each edge, release conditions in priority order:
  - enable=0 -> release.
  - requests[grant_idx]=0 -> release.
  - TIMEOUT>0 && hcnt==TIMEOUT-1 && any other request set -> release.
  - Otherwise hold the grant and increment hcnt, saturating at TIMEOUT-1.
  - hcnt does not advance past TIMEOUT-1 while no other request is pending, so a lone owner is never evicted.
- Release:
  - Next cycle grants=0, grant_idx=0, busy=0, state IDLE.
  - Always exactly one dead cycle between consecutive grants; no back-to-back handover.
- latch is ignored in GRANTED; it cannot preempt an active grant.
- Request changes of non-owners during GRANTED have no effect, except enabling the timeout.
- Simultaneous release and new request at the same edge: release wins; the new request is arbitrated from IDLE on a following edge.
- Boundary cases:
  - WIDTH=1: the round-robin pointer stays 0; timeout never fires because there is no other requester.
  - TIMEOUT=1: a waiting competitor evicts the owner after 1 held cycle.
- granted may drop combinationally in the cycle the owner deasserts, before grants clears.

Test Plan:
- RR_MODE=0, requests=8'b0110_1000, enable=1, latch=1 for 1 cycle -> after next edge grants=8'b0000_1000, grant_idx=3, busy=1, granted=1; held while bit 3 stays high.
- RR_MODE=1, requests=8'hFF, each owner drops its request for 1 cycle after being granted -> grant order 0,1,2,...,7,0, with exactly one all-zero grants cycle between successive grants.
- TIMEOUT=4, requests=8'h03 held constant, latch=1 -> grants=8'h01 for 4 cycles, then 1 idle cycle, then grants=8'h02 (RR_MODE=1); with requests=8'h01 only, grants=8'h01 persists indefinitely.
- In GRANTED with grants=8'h10, drive enable=0 -> next edge grants=0, busy=0; with enable=1, latch=0 and requests=8'hFF -> grants remains 0.
- Assert rst low mid-grant between clock edges -> grants, grant_idx and busy go to 0 immediately; after release the first RR grant with requests=8'hFF is index 0.
- In GRANTED (grants=8'h01), owner drops and requester 5 rises at the same edge -> 1 idle cycle, then grants=8'h20.
